// File: rtl/boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : boot_sequencer
// Description : Registered FSM that brings the FPGA top level up after the
//               start switch is raised:
//                 system reset -> RAM load (done/timeout) -> CPU reset ->
//                 settle -> bounded RDY run window -> HALT.
//               While running it snoops CPU writes to WATCH_ADDR and latches
//               the byte for the seven-segment display path.
// Ports       : clk, reset (sync, active-high)
//               start        - start switch level (rise launches, low aborts)
//               loader_done  - RAM loader finished
//               cpu_AB/DO/WE - CPU bus snoop inputs
//               sys_reset, load, RDY - sequencing outputs
//               busy, run_done, load_err, state - status/debug
//               result, result_valid - captured watch-address byte
// Revision    : 1.0 - initial release
// ============================================================================
module boot_sequencer #(
    parameter int          RST_CYCLES     = 8,
    parameter int          LOAD_TIMEOUT   = 1024,
    parameter int          CPU_RST_CYCLES = 10,
    parameter int          SETTLE_CYCLES  = 10,
    parameter int          RUN_CYCLES     = 1380,
    parameter logic [15:0] WATCH_ADDR     = 16'h0200,
    parameter int          CNT_W          = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        loader_done,
    input  logic [15:0] cpu_AB,
    input  logic [7:0]  cpu_DO,
    input  logic        cpu_WE,
    output logic        sys_reset,
    output logic        load,
    output logic        RDY,
    output logic        busy,
    output logic        run_done,
    output logic        load_err,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYS_RST = 3'd1,
        S_LOAD    = 3'd2,
        S_CPU_RST = 3'd3,
        S_SETTLE  = 3'd4,
        S_RUN     = 3'd5,
        S_HALT    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    // Terminal counts: the counter is 0 on the first cycle of a phase, so a
    // phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LOAD_LAST   = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CPURST_LAST = CNT_W'(CPU_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RUN_LAST    = CNT_W'(RUN_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start_q;
    logic             w_start_rise;
    logic             w_busy_now;
    logic             w_capture;

    // Registered copies of the decoded outputs
    logic r_sys_reset, r_load, r_rdy, r_busy, r_run_done, r_load_err;
    logic [7:0] r_result;
    logic       r_result_valid;

    // Next-cycle output decode (from w_next, so outputs move with state)
    logic w_sys_reset, w_load, w_rdy, w_busy, w_run_done, w_load_err;

    assign w_start_rise = start & ~r_start_q;
    assign w_busy_now   = (r_state == S_SYS_RST) || (r_state == S_LOAD) ||
                          (r_state == S_CPU_RST) || (r_state == S_SETTLE) ||
                          (r_state == S_RUN);
    // r_state==S_RUN is exactly the cycles where the registered RDY is high
    assign w_capture    = (r_state == S_RUN) && cpu_WE && (cpu_AB == WATCH_ADDR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_rise)         w_next = S_SYS_RST;
            S_SYS_RST: if (r_cnt == c_RST_LAST)  w_next = S_LOAD;
            S_LOAD: begin
                // done has priority over a coincident timeout
                if (loader_done)                 w_next = S_CPU_RST;
                else if (r_cnt == c_LOAD_LAST)   w_next = S_ERR;
            end
            S_CPU_RST: if (r_cnt == c_CPURST_LAST) w_next = S_SETTLE;
            S_SETTLE:  if (r_cnt == c_SETTLE_LAST) w_next = S_RUN;
            S_RUN:     if (r_cnt == c_RUN_LAST)    w_next = S_HALT;
            S_HALT:    if (w_start_rise)         w_next = S_SYS_RST;
            S_ERR:     if (w_start_rise)         w_next = S_SYS_RST;
            default:                             w_next = S_IDLE;
        endcase
        // Dropping the switch aborts any active phase
        if (w_busy_now && !start) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        w_sys_reset = 1'b0;
        w_load      = 1'b0;
        w_rdy       = 1'b0;
        w_busy      = 1'b0;
        w_run_done  = 1'b0;
        w_load_err  = 1'b0;
        case (w_next)
            S_IDLE:    w_sys_reset = 1'b1;
            S_SYS_RST: begin w_sys_reset = 1'b1; w_busy = 1'b1; end
            S_LOAD:    begin w_load      = 1'b1; w_busy = 1'b1; end
            S_CPU_RST: begin w_sys_reset = 1'b1; w_busy = 1'b1; end
            S_SETTLE:  w_busy = 1'b1;
            S_RUN:     begin w_rdy       = 1'b1; w_busy = 1'b1; end
            S_HALT:    w_run_done = 1'b1;
            S_ERR:     begin w_sys_reset = 1'b1; w_load_err = 1'b1; end
            default:   w_sys_reset = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_start_q      <= 1'b0;
            r_sys_reset    <= 1'b1;
            r_load         <= 1'b0;
            r_rdy          <= 1'b0;
            r_busy         <= 1'b0;
            r_run_done     <= 1'b0;
            r_load_err     <= 1'b0;
            r_result       <= 8'h00;
            r_result_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_start_q   <= start;
            r_sys_reset <= w_sys_reset;
            r_load      <= w_load;
            r_rdy       <= w_rdy;
            r_busy      <= w_busy;
            r_run_done  <= w_run_done;
            r_load_err  <= w_load_err;
            if (w_capture) begin
                r_result       <= cpu_DO;
                r_result_valid <= 1'b1;
            end else if (w_next == S_SYS_RST && r_state != S_SYS_RST) begin
                // A new sequence invalidates the previous capture
                r_result_valid <= 1'b0;
            end
        end
    end

    assign sys_reset    = r_sys_reset;
    assign load         = r_load;
    assign RDY          = r_rdy;
    assign busy         = r_busy;
    assign run_done     = r_run_done;
    assign load_err     = r_load_err;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_sequencer
// Description : Directed self-checking bench for boot_sequencer (defaults).
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        loader_done = 1'b0;
    logic [15:0] cpu_AB = 16'h0000;
    logic [7:0]  cpu_DO = 8'h00;
    logic        cpu_WE = 1'b0;
    logic        sys_reset, load, RDY, busy, run_done, load_err, result_valid;
    logic [7:0]  result;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    always #5 clk = ~clk;

    boot_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .loader_done  (loader_done),
        .cpu_AB       (cpu_AB),
        .cpu_DO       (cpu_DO),
        .cpu_WE       (cpu_WE),
        .sys_reset    (sys_reset),
        .load         (load),
        .RDY          (RDY),
        .busy         (busy),
        .run_done     (run_done),
        .load_err     (load_err),
        .result       (result),
        .result_valid (result_valid),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Count consecutive falling edges on which state==s (bounded)
    task automatic count_state(input logic [2:0] s, input int limit, output int cnt);
        cnt = 0;
        while (state == s && cnt < limit) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int limit);
        int k;
        k = 0;
        while (state != s && k < limit) begin
            k++;
            @(negedge clk);
        end
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, {29'd0, state}, 32'd0);
        chk({tag, "_outs"}, {26'd0, sys_reset, load, RDY, busy, run_done, load_err},
            32'b100000);
    endtask

    initial begin
        // ---------------- Reset ----------------
        tick(3);
        chk_reset_vals("rst");
        chk("rst_result", {23'd0, result_valid, result}, 32'h000);
        reset = 1'b0;
        tick(2);
        chk("idle_hold", {29'd0, state}, 32'd0);

        // ---------------- Normal run with captures ----------------
        start = 1'b1;
        tick(1);
        chk("sysrst_outs", {29'd0, sys_reset, load, RDY}, 32'b100);
        count_state(3'd1, 50, n);
        chk("sysrst_len", n, 8);
        chk("load_outs", {28'd0, sys_reset, load, RDY, busy}, 32'b0101);
        tick(19);                                   // 20th LOAD cycle
        chk("load_20", {29'd0, state}, 32'd2);
        loader_done = 1'b1;
        tick(1);
        loader_done = 1'b0;
        chk("cpurst_entry", {29'd0, state, sys_reset, load}, {27'd0, 3'd3, 2'b10});
        count_state(3'd3, 50, n);
        chk("cpurst_len", n, 10);
        chk("settle_outs", {29'd0, sys_reset, load, RDY}, 32'b000);
        count_state(3'd4, 50, n);
        chk("settle_len", n, 10);
        chk("run_rdy", {31'd0, RDY}, 32'd1);
        cpu_WE = 1'b1; cpu_AB = 16'h0200; cpu_DO = 8'hA5;
        tick(1);
        chk("cap_first", {24'd0, result}, 32'hA5);
        cpu_DO = 8'h3C;
        tick(1);
        cpu_AB = 16'h0201; cpu_DO = 8'hFF;
        tick(1);
        cpu_WE = 1'b0;
        tick(1);
        chk("cap_last", {23'd0, result_valid, result}, 32'h13C);
        count_state(3'd5, 2000, n);
        chk("run_len", n + 4, 1380);
        chk("halt", {29'd0, state, run_done, RDY, sys_reset}, {26'd0, 3'd6, 3'b100});
        start = 1'b0;
        tick(3);
        chk("halt_hold", {29'd0, state}, 32'd6);

        // ---------------- Load timeout ----------------
        start = 1'b1;
        tick(1);
        chk("restart", {23'd0, result_valid, result}, 32'h03C);
        chk("restart_state", {29'd0, state}, 32'd1);
        count_state(3'd1, 50, n);
        count_state(3'd2, 2000, n);
        chk("timeout_len", n, 1024);
        chk("err", {29'd0, state, load_err, sys_reset, load},
            {26'd0, 3'd7, 3'b110});
        start = 1'b0;
        tick(2);
        chk("err_hold", {29'd0, state}, 32'd7);

        // ---------------- Done in last LOAD cycle, then abort ----------------
        start = 1'b1;
        tick(1);
        chk("err_restart", {29'd0, state}, 32'd1);
        count_state(3'd1, 50, n);
        cpu_WE = 1'b1; cpu_AB = 16'h0200; cpu_DO = 8'h77;
        tick(1);
        cpu_WE = 1'b0;
        chk("load_write_ign", {24'd0, result}, 32'h3C);
        tick(1022);                                 // 1024th LOAD cycle
        chk("load_1024", {29'd0, state}, 32'd2);
        loader_done = 1'b1;
        tick(1);
        loader_done = 1'b0;
        chk("done_wins", {29'd0, state}, 32'd3);
        count_state(3'd3, 50, n);
        count_state(3'd4, 50, n);
        chk("run2", {29'd0, state}, 32'd5);
        cpu_WE = 1'b1; cpu_AB = 16'h0200; cpu_DO = 8'h5A;
        tick(1);
        cpu_WE = 1'b0;
        tick(498);                                  // 500th RUN cycle
        chk("run_500", {29'd0, state}, 32'd5);
        start = 1'b0;
        tick(1);
        chk("abort", {29'd0, state, RDY, sys_reset, busy}, {26'd0, 3'd0, 3'b010});
        chk("abort_keep", {23'd0, result_valid, result}, 32'h15A);

        // ---------------- Reset during SETTLE ----------------
        start = 1'b1;
        loader_done = 1'b1;
        tick(1);
        wait_state("reach_settle", 3'd4, 100);
        reset = 1'b1;
        start = 1'b0;
        tick(1);
        chk_reset_vals("mid_rst");
        chk("mid_rst_result", {23'd0, result_valid, result}, 32'h000);
        reset = 1'b0;
        loader_done = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (RDY !== 1'b0 || state !== 3'd0) n++;
            tick(1);
        end
        chk("no_rdy_glitch", n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: observed timeout expected completion");
    end

endmodule
`default_nettype wire

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
Registered FSM that brings the FPGA top level up after the start switch is raised. It replaces the free-running cycle-counter sequencing in the top level. Sequence: system reset pulse, RAM load phase closed by a done/timeout handshake from the RAM loader, CPU reset pulse, settle window, then a bounded RDY run window. During the run it snoops CPU bus writes to a watch address and latches the byte for the seven-segment display path.

Parameters:
RST_CYCLES, 8, cycles sys_reset held at start of sequence (>=1)
LOAD_TIMEOUT, 1024, max cycles in LOAD waiting for loader_done before error (>=1)
CPU_RST_CYCLES, 10, cycles sys_reset held after load (>=1)
SETTLE_CYCLES, 10, cycles with reset low and RDY low before run (>=1)
RUN_CYCLES, 1380, cycles RDY held high (>=1)
WATCH_ADDR, 16'h0200, CPU write address captured into result
CNT_W, 24, phase counter width; every cycle parameter < 2**CNT_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  start switch level; rising edge launches sequence, low aborts
loader_done  in  1  RAM loader finished (level, sampled each cycle)
cpu_AB  in  16  CPU address bus
cpu_DO  in  8  CPU data out
cpu_WE  in  1  CPU write enable
sys_reset  out  1  reset to CPU and RAM loader
load  out  1  RAM mux select / loader enable
RDY  out  1  CPU ready
busy  out  1  high in SYS_RST, LOAD, CPU_RST, SETTLE, RUN
run_done  out  1  high in HALT
load_err  out  1  high in ERR
result  out  8  last byte written by CPU to WATCH_ADDR
result_valid  out  1  result holds a capture from the current run
state  out  3  encoded FSM state for debug

Behaviour:
- All outputs registered; state and outputs change on the same clk edge. Reset is synchronous to clk.
- On reset:
  - state=IDLE.
  - sys_reset=1; load=0; RDY=0; busy=0; run_done=0; load_err=0.
  - result=8'h00; result_valid=0; counter=0; start edge detector cleared (start_q=0).
- Start rise = start & ~start_q, with start_q registered.
- State encoding: IDLE=0, SYS_RST=1, LOAD=2, CPU_RST=3, SETTLE=4, RUN=5, HALT=6, ERR=7.
- IDLE:
  - sys_reset=1, load=0, RDY=0.
  - On start rise: go to SYS_RST, counter=0, result_valid=0.
- SYS_RST:
  - sys_reset=1, load=0, RDY=0.
  - Occupies exactly RST_CYCLES cycles, then LOAD.
- LOAD:
  - sys_reset=0, load=1, RDY=0.
  - loader_done=1 -> CPU_RST.
  - Otherwise, after LOAD_TIMEOUT cycles in LOAD -> ERR.
  - If loader_done and timeout occur in the same cycle, done wins.
- CPU_RST:
  - sys_reset=1, load=0, RDY=0.
  - Exactly CPU_RST_CYCLES cycles, then SETTLE.
- SETTLE:
  - sys_reset=0, load=0, RDY=0.
  - Exactly SETTLE_CYCLES cycles, then RUN.
- RUN:
  - sys_reset=0, load=0, RDY=1.
  - Exactly RUN_CYCLES cycles, then HALT.
- HALT:
  - sys_reset=0, RDY=0, run_done=1.
  - Holds regardless of start level; start rise -> SYS_RST (restart, result_valid cleared).
- ERR:
  - sys_reset=1, load=0, RDY=0, load_err=1.
  - Holds; start rise -> SYS_RST.
- Abort: start=0 in any busy state -> IDLE on the next edge. Outputs take IDLE values; result and result_valid are kept.
- Capture:
  - Condition: state==RUN && cpu_WE && cpu_AB==WATCH_ADDR, evaluated on the registered RDY=1.
  - Action: result<=cpu_DO, result_valid<=1.
  - Multiple writes in a run: the last write wins.
  - Writes outside RUN are ignored.
- Counter: cleared on every state transition; increments otherwise; never wraps within a phase, given the parameter limits.
- reset asserted mid-run overrides everything on the next edge.

Test Plan:
- Defaults, reset then start 0->1, loader_done raised 20 cycles into LOAD -> sys_reset high 8 cycles; load high 20 cycles; sys_reset high 10; RDY low 10; RDY high exactly 1380 cycles; then run_done=1, state=6.
- loader_done held 0 -> after 1024 LOAD cycles, state=7, load_err=1, sys_reset=1, load=0; a new start rise restarts in SYS_RST.
- In RUN, CPU writes 8'hA5 then 8'h3C to 16'h0200 and 8'hFF to 16'h0201 -> result=8'h3C, result_valid=1. A write to 16'h0200 during LOAD does not change result.
- start dropped to 0 in the 500th RUN cycle -> next edge state=0, RDY=0, sys_reset=1; result is retained.
- loader_done rises in exactly the 1024th LOAD cycle -> CPU_RST, not ERR.
- reset pulsed during SETTLE -> all outputs at reset values; no spurious RDY pulse.
